// File: rtl/ps2_mouse_ctrl_pkg.sv
// Shared definitions for the PS/2 mouse controller: init FSM states, command and
// response bytes, and bit positions inside the first byte of a stream packet.
package ps2_mouse_ctrl_pkg;

   typedef enum logic [2:0] {
      SEND_RST  = 3'd0,
      WAIT_ACK1 = 3'd1,
      WAIT_BAT  = 3'd2,
      WAIT_ID   = 3'd3,
      SEND_EN   = 3'd4,
      WAIT_ACK2 = 3'd5,
      STREAM    = 3'd6,
      ERROR     = 3'd7
   } state_e;

   localparam logic [7:0] CMD_RESET    = 8'hFF;
   localparam logic [7:0] CMD_ENABLE   = 8'hF4;
   localparam logic [7:0] RSP_ACK      = 8'hFA;
   localparam logic [7:0] RSP_RESEND   = 8'hFE;
   localparam logic [7:0] RSP_BAT_OK   = 8'hAA;
   localparam logic [7:0] RSP_MOUSE_ID = 8'h00;

   localparam int B0_BTN_LSB = 0;
   localparam int B0_SYNC    = 3;
   localparam int B0_XSIGN   = 4;
   localparam int B0_YSIGN   = 5;
   localparam int B0_XOVF    = 6;
   localparam int B0_YOVF    = 7;

endpackage

// File: rtl/ps2_pkt_assembler.sv
// Collects the three stream bytes into one movement report, resyncing on the
// header sync bit and abandoning a partial packet after a long inter-byte gap.
module ps2_pkt_assembler
   import ps2_mouse_ctrl_pkg::*;
#(
   parameter int unsigned PKT_GAP_CYC = 100_000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en_i,
   input  logic       clr_i,
   input  logic [7:0] rx_data_i,
   input  logic       rx_ready_i,
   output logic       pkt_valid_o,
   output logic [8:0] dx_o,
   output logic [8:0] dy_o,
   output logic [2:0] btn_o,
   output logic [1:0] ovf_o
);

   logic [1:0]  idx_q, idx_d;
   logic [7:0]  b0_q, b0_d;
   logic [7:0]  b1_q, b1_d;
   logic [31:0] gap_q, gap_d;
   logic        pkt_valid_q, pkt_valid_d;
   logic [8:0]  dx_q, dx_d;
   logic [8:0]  dy_q, dy_d;
   logic [2:0]  btn_q, btn_d;
   logic [1:0]  ovf_q, ovf_d;
   logic        gap_to;
   logic [1:0]  idx_eff;

   always_comb begin
      idx_d       = idx_q;
      b0_d        = b0_q;
      b1_d        = b1_q;
      gap_d       = gap_q;
      pkt_valid_d = 1'b0;
      dx_d        = dx_q;
      dy_d        = dy_q;
      btn_d       = btn_q;
      ovf_d       = ovf_q;
      gap_to      = (idx_q != 2'd0) && (gap_q >= PKT_GAP_CYC);
      // a byte landing on the gap-timeout cycle starts a fresh packet
      idx_eff     = gap_to ? 2'd0 : idx_q;

      if (clr_i || !en_i) begin
         idx_d = 2'd0;
         gap_d = '0;
      end else begin
         idx_d = idx_eff;
         gap_d = (idx_eff == 2'd0) ? '0 : gap_q + 32'd1;
         if (rx_ready_i) begin
            gap_d = '0;
            case (idx_eff)
               2'd0: begin
                  if (rx_data_i[B0_SYNC]) begin
                     b0_d  = rx_data_i;
                     idx_d = 2'd1;
                  end
               end
               2'd1: begin
                  b1_d  = rx_data_i;
                  idx_d = 2'd2;
               end
               default: begin
                  idx_d = 2'd0;
                  if (b0_q[B0_SYNC]) begin
                     pkt_valid_d = 1'b1;
                     dx_d        = {b0_q[B0_XSIGN], b1_q};
                     dy_d        = {b0_q[B0_YSIGN], rx_data_i};
                     btn_d       = b0_q[B0_BTN_LSB +: 3];
                     ovf_d       = {b0_q[B0_YOVF], b0_q[B0_XOVF]};
                  end
               end
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_q       <= 2'd0;
         b0_q        <= 8'h00;
         b1_q        <= 8'h00;
         gap_q       <= '0;
         pkt_valid_q <= 1'b0;
         dx_q        <= 9'h000;
         dy_q        <= 9'h000;
         btn_q       <= 3'b000;
         ovf_q       <= 2'b00;
      end else begin
         idx_q       <= idx_d;
         b0_q        <= b0_d;
         b1_q        <= b1_d;
         gap_q       <= gap_d;
         pkt_valid_q <= pkt_valid_d;
         dx_q        <= dx_d;
         dy_q        <= dy_d;
         btn_q       <= btn_d;
         ovf_q       <= ovf_d;
      end
   end

   assign pkt_valid_o = pkt_valid_q;
   assign dx_o        = dx_q;
   assign dy_o        = dy_q;
   assign btn_o       = btn_q;
   assign ovf_o       = ovf_q;

endmodule

// File: rtl/ps2_mouse_ctrl.sv
// PS/2 mouse controller: reset/enable init handshake with retries and timeouts,
// then hands incoming stream bytes to the packet assembler.
module ps2_mouse_ctrl
   import ps2_mouse_ctrl_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYC = 50_000_000,
   parameter int unsigned PKT_GAP_CYC = 100_000,
   parameter int unsigned MAX_RETRY   = 3
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       init_req,
   input  logic [7:0] rx_data,
   input  logic       rx_ready,
   input  logic       tx_busy,
   output logic [7:0] tx_data,
   output logic       tx_start,
   output logic       pkt_valid,
   output logic [8:0] dx,
   output logic [8:0] dy,
   output logic [2:0] btn,
   output logic [1:0] ovf,
   output logic       init_done,
   output logic       init_error
);

   state_e      state_q, state_d;
   logic [31:0] to_q, to_d;
   logic [31:0] retry_q, retry_d;
   logic        tx_start_q, tx_start_d;
   logic [7:0]  tx_data_q, tx_data_d;
   logic        fail;
   logic        is_wait;

   always_comb begin
      state_d    = state_q;
      retry_d    = retry_q;
      tx_start_d = 1'b0;
      tx_data_d  = tx_data_q;
      fail       = 1'b0;
      is_wait    = state_q inside {WAIT_ACK1, WAIT_BAT, WAIT_ID, WAIT_ACK2};

      if (init_req) begin
         state_d = SEND_RST;
         retry_d = '0;
      end else begin
         case (state_q)
            SEND_RST: if (!tx_busy) begin
               tx_start_d = 1'b1;
               tx_data_d  = CMD_RESET;
               state_d    = WAIT_ACK1;
            end
            SEND_EN: if (!tx_busy) begin
               tx_start_d = 1'b1;
               tx_data_d  = CMD_ENABLE;
               state_d    = WAIT_ACK2;
            end
            WAIT_ACK1: if (rx_ready) begin
               if (rx_data == RSP_ACK)         state_d = WAIT_BAT;
               else if (rx_data == RSP_RESEND) state_d = SEND_RST;
               else                            fail    = 1'b1;
            end
            WAIT_BAT: if (rx_ready) begin
               if (rx_data == RSP_BAT_OK) state_d = WAIT_ID;
               else                       fail    = 1'b1;
            end
            WAIT_ID: if (rx_ready) begin
               if (rx_data == RSP_MOUSE_ID) state_d = SEND_EN;
               else                         fail    = 1'b1;
            end
            WAIT_ACK2: if (rx_ready) begin
               if (rx_data == RSP_ACK)         state_d = STREAM;
               else if (rx_data == RSP_RESEND) state_d = SEND_EN;
               else                            fail    = 1'b1;
            end
            default: ;
         endcase

         // a byte arriving on the timeout cycle is judged on its value instead
         if (is_wait && !rx_ready && (to_q >= TIMEOUT_CYC)) fail = 1'b1;

         if (fail) begin
            retry_d = retry_q + 32'd1;
            state_d = (retry_q + 32'd1 >= MAX_RETRY) ? ERROR : SEND_RST;
         end
      end

      to_d = (is_wait && !rx_ready && (state_d == state_q)) ? to_q + 32'd1 : '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= SEND_RST;
         to_q       <= '0;
         retry_q    <= '0;
         tx_start_q <= 1'b0;
         tx_data_q  <= 8'h00;
      end else begin
         state_q    <= state_d;
         to_q       <= to_d;
         retry_q    <= retry_d;
         tx_start_q <= tx_start_d;
         tx_data_q  <= tx_data_d;
      end
   end

   assign tx_start   = tx_start_q;
   assign tx_data    = tx_data_q;
   assign init_done  = (state_q == STREAM);
   assign init_error = (state_q == ERROR);

   ps2_pkt_assembler #(
      .PKT_GAP_CYC (PKT_GAP_CYC)
   ) u_asm (
      .clk         (clk),
      .rst_n       (rst_n),
      .en_i        (state_q == STREAM),
      .clr_i       (init_req),
      .rx_data_i   (rx_data),
      .rx_ready_i  (rx_ready),
      .pkt_valid_o (pkt_valid),
      .dx_o        (dx),
      .dy_o        (dy),
      .btn_o       (btn),
      .ovf_o       (ovf)
   );

endmodule

// File: tb/tb_ps2_mouse_ctrl.sv
// Bench for ps2_mouse_ctrl: directed init/stream scenarios plus random packets
// checked against an arithmetic packet model.
module tb_ps2_mouse_ctrl;

   localparam int TO_CYC  = 100;
   localparam int GAP_CYC = 50;

   logic       clk = 1'b0;
   logic       rst_n, init_req, rx_ready, tx_busy;
   logic [7:0] rx_data;
   logic [7:0] tx_data;
   logic       tx_start, pkt_valid, init_done, init_error;
   logic [8:0] dx, dy;
   logic [2:0] btn;
   logic [1:0] ovf;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic        ext_busy;
   logic [7:0]  tx_log[$];
   logic [22:0] pkt_log[$];
   logic [22:0] exp_q[$];

   always #5 clk = ~clk;

   ps2_mouse_ctrl #(
      .TIMEOUT_CYC (TO_CYC),
      .PKT_GAP_CYC (GAP_CYC),
      .MAX_RETRY   (3)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .init_req   (init_req),
      .rx_data    (rx_data),
      .rx_ready   (rx_ready),
      .tx_busy    (tx_busy),
      .tx_data    (tx_data),
      .tx_start   (tx_start),
      .pkt_valid  (pkt_valid),
      .dx         (dx),
      .dy         (dy),
      .btn        (btn),
      .ovf        (ovf),
      .init_done  (init_done),
      .init_error (init_error)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Transmitter model: logs each command and stays busy for three cycles after it.
   initial begin
      int busy_left = 0;
      tx_busy = 1'b1;
      forever begin
         @(negedge clk);
         if (tx_start === 1'b1) begin
            check("tx_start_while_busy", {31'd0, tx_busy}, 32'd0);
            tx_log.push_back(tx_data);
            busy_left = 3;
         end else if (busy_left > 0) begin
            busy_left--;
         end
         tx_busy = (busy_left != 0) || ext_busy;
      end
   end

   always @(negedge clk) begin
      if (pkt_valid === 1'b1) pkt_log.push_back({dx, dy, btn, ovf});
   end

   // Reference packet: signed motion as byte value minus 256 when the sign bit is set.
   function automatic logic [22:0] exp_pkt(input int b0, input int b1, input int b2);
      int x, y;
      logic [8:0] xd, yd;
      x  = b1 - ((b0 / 16) % 2) * 256;
      y  = b2 - ((b0 / 32) % 2) * 256;
      xd = x[8:0];
      yd = y[8:0];
      return {xd, yd, 3'(b0 % 8), 2'(b0 / 64)};
   endfunction

   task automatic send_byte(input logic [7:0] b);
      @(negedge clk);
      rx_data  = b;
      rx_ready = 1'b1;
      @(negedge clk);
      rx_ready = 1'b0;
   endtask

   task automatic pulse_init();
      @(negedge clk);
      init_req = 1'b1;
      @(negedge clk);
      init_req = 1'b0;
   endtask

   task automatic wait_tx(input logic [7:0] exp, input string tag);
      int t = 0;
      logic [7:0] got;
      while (tx_log.size() == 0 && t < 1000) begin
         @(negedge clk);
         t++;
      end
      got = 8'hxx;
      if (tx_log.size() != 0) got = tx_log.pop_front();
      check(tag, {24'd0, got}, {24'd0, exp});
   endtask

   task automatic wait_error(input string tag);
      int t = 0;
      while (init_error !== 1'b1 && t < 3000) begin
         @(negedge clk);
         t++;
      end
      check(tag, {31'd0, init_error}, 32'd1);
   endtask

   task automatic do_init(input bit fe1, input bit fe2, input string tag);
      wait_tx(8'hFF, {tag, "_rst_cmd"});
      if (fe1) begin
         send_byte(8'hFE);
         wait_tx(8'hFF, {tag, "_rst_resend"});
      end
      send_byte(8'hFA);
      send_byte(8'hAA);
      send_byte(8'h00);
      wait_tx(8'hF4, {tag, "_en_cmd"});
      if (fe2) begin
         send_byte(8'hFE);
         wait_tx(8'hF4, {tag, "_en_resend"});
      end
      check({tag, "_not_done"}, {31'd0, init_done}, 32'd0);
      send_byte(8'hFA);
      check({tag, "_done"}, {31'd0, init_done}, 32'd1);
   endtask

   task automatic send_pkt_timed(input logic [7:0] b0, input logic [7:0] b1,
                                 input logic [7:0] b2, input string tag);
      send_byte(b0);
      send_byte(b1);
      @(negedge clk);
      rx_data  = b2;
      rx_ready = 1'b1;
      check({tag, "_pre"}, {31'd0, pkt_valid}, 32'd0);
      @(negedge clk);
      rx_ready = 1'b0;
      check({tag, "_strobe"}, {31'd0, pkt_valid}, 32'd1);
      @(negedge clk);
      check({tag, "_one_cycle"}, {31'd0, pkt_valid}, 32'd0);
   endtask

   task automatic check_pkts(input string tag);
      logic [22:0] e, o;
      repeat (3) @(negedge clk);
      check({tag, "_count"}, pkt_log.size(), exp_q.size());
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         o = 'x;
         if (pkt_log.size() != 0) o = pkt_log.pop_front();
         check(tag, {9'd0, o}, {9'd0, e});
      end
      pkt_log.delete();
   endtask

   initial begin
      logic [7:0] a, b, c;
      rst_n    = 1'b0;
      init_req = 1'b0;
      rx_ready = 1'b0;
      rx_data  = 8'h00;
      ext_busy = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_tx_start", {31'd0, tx_start}, 32'd0);
      check("rst_tx_data", {24'd0, tx_data}, 32'd0);
      check("rst_pkt_valid", {31'd0, pkt_valid}, 32'd0);
      check("rst_fields", {9'd0, dx, dy, btn, ovf}, 32'd0);
      check("rst_flags", {30'd0, init_done, init_error}, 32'd0);

      // Init starts on its own but must wait for the transmitter to go idle.
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      check("hold_while_busy", tx_log.size(), 0);
      ext_busy = 1'b0;
      do_init(1'b0, 1'b0, "init");

      send_pkt_timed(8'h39, 8'h10, 8'hF0, "pkt39");
      exp_q.push_back(exp_pkt(8'h39, 8'h10, 8'hF0));
      check_pkts("pkt39_fields");

      send_pkt_timed(8'h29, 8'h10, 8'hF0, "pkt29");
      exp_q.push_back({9'h010, 9'h1F0, 3'b001, 2'b00});
      check_pkts("pkt29_fields");

      send_byte(8'h00);
      send_byte(8'h08);
      send_byte(8'h05);
      send_byte(8'h03);
      exp_q.push_back({9'd5, 9'd3, 3'b000, 2'b00});
      check_pkts("resync");

      send_byte(8'h08);
      send_byte(8'h01);
      repeat (GAP_CYC + 20) @(negedge clk);
      send_byte(8'h09);
      send_byte(8'h02);
      send_byte(8'h02);
      exp_q.push_back({9'd2, 9'd2, 3'b001, 2'b00});
      check_pkts("gap");

      for (int p = 0; p < 25; p++) begin
         if ($urandom_range(0, 3) == 0) begin
            send_byte(8'($urandom_range(0, 255)) & 8'hF7);
            repeat ($urandom_range(0, 4)) @(negedge clk);
         end
         a = 8'($urandom_range(0, 255)) | 8'h08;
         b = 8'($urandom_range(0, 255));
         c = 8'($urandom_range(0, 255));
         exp_q.push_back(exp_pkt(a, b, c));
         send_byte(a);
         repeat ($urandom_range(0, 4)) @(negedge clk);
         send_byte(b);
         repeat ($urandom_range(0, 4)) @(negedge clk);
         send_byte(c);
         repeat ($urandom_range(0, 4)) @(negedge clk);
      end
      check_pkts("rand");

      // Reset in the middle of a packet must not leave a stale byte index behind.
      send_byte(8'h08);
      send_byte(8'h01);
      @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      check("midrst_fields", {9'd0, dx, dy, btn, ovf}, 32'd0);
      check("midrst_done", {31'd0, init_done}, 32'd0);
      rst_n = 1'b1;
      do_init(1'b0, 1'b0, "reinit");
      send_byte(8'h0A);
      send_byte(8'h03);
      send_byte(8'h04);
      exp_q.push_back({9'd3, 9'd4, 3'b010, 2'b00});
      check_pkts("after_midrst");

      pulse_init();
      do_init(1'b1, 1'b0, "fe_ack1");
      pulse_init();
      do_init(1'b0, 1'b1, "fe_ack2");

      // Silence: three reset attempts, then a sticky error.
      pulse_init();
      wait_error("err_reached");
      check("err_tx_count", tx_log.size(), 3);
      while (tx_log.size() != 0) check("err_tx_byte", {24'd0, tx_log.pop_front()}, 32'hFF);
      send_byte(8'hFA);
      repeat (300) @(negedge clk);
      check("err_sticky", {31'd0, init_error}, 32'd1);
      check("err_no_tx", tx_log.size(), 0);

      // A resend request does not use up an attempt: four commands before error.
      pulse_init();
      check("err_cleared", {31'd0, init_error}, 32'd0);
      wait_tx(8'hFF, "err_reinit_cmd");
      send_byte(8'hFE);
      wait_error("err_after_fe");
      check("err_fe_tx_count", tx_log.size(), 3);
      while (tx_log.size() != 0) check("err_fe_tx_byte", {24'd0, tx_log.pop_front()}, 32'hFF);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
